pipeline_hazard_ctrl: RTL

//  Central producer of the freeze/flush controls consumed by every pipeline stage register
//  (IF, ID, EXE, MEM, WB). Detects RAW hazards, handles taken-branch flushes and holds the whole

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 15 +
 rtl/pipeline_hazard_ctrl_hazard_detect_unit.sv | 33 +++
 rtl/pipeline_hazard_ctrl.sv | 99 +++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM state and the stage-register NOP/flush encodings.
// Optional feature macro used by this slice: FORWARDING_EN.
package pipeline_hazard_ctrl_pkg;

   typedef enum logic [0:0] {
      IDLE     = 1'b0,
      MEM_WAIT = 1'b1
   } state_t;

   // Instruction word loaded into a stage register when it is flushed or bubbled.
   localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
   localparam logic        FLUSH_VLD  = 1'b0;
   localparam int unsigned WAIT_CNT_W = 8;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect_unit.sv
// Combinational RAW hazard detection against the EXE and MEM destinations.
// FORWARDING_EN defined: only load-use hazards on the EXE destination stall.
module hazard_detect_unit #(
   parameter int unsigned REG_W = 4
) (
   input  logic [REG_W-1:0] id_src1,
   input  logic [REG_W-1:0] id_src2,
   input  logic             id_two_src,
   input  logic [REG_W-1:0] exe_dest,
   input  logic             exe_wb_en,
   input  logic             exe_mem_read,
   input  logic [REG_W-1:0] mem_dest,
   input  logic             mem_wb_en,
   output logic             hazard
);

   logic exe_match;
   logic mem_match;

   assign exe_match = exe_wb_en & ((id_src1 == exe_dest) | (id_two_src & (id_src2 == exe_dest)));
   assign mem_match = mem_wb_en & ((id_src1 == mem_dest) | (id_two_src & (id_src2 == mem_dest)));

`ifdef FORWARDING_EN
   logic unused_mem_match;
   assign unused_mem_match = mem_match;
   assign hazard = exe_mem_read & exe_match;
`else
   logic unused_exe_mem_read;
   assign unused_exe_mem_read = exe_mem_read;
   assign hazard = exe_match | mem_match;
`endif

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Freeze/flush control for all pipeline stage registers: RAW stalls, branch flushes, memory-wait holds.
// Hazard rule depends on the FORWARDING_EN macro (see hazard_detect_unit).
module pipeline_hazard_ctrl
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter int unsigned REG_W       = 4,
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [REG_W-1:0] id_src1,
   input  logic [REG_W-1:0] id_src2,
   input  logic             id_two_src,
   input  logic [REG_W-1:0] exe_dest,
   input  logic             exe_wb_en,
   input  logic             exe_mem_read,
   input  logic [REG_W-1:0] mem_dest,
   input  logic             mem_wb_en,
   input  logic             branch_taken,
   input  logic             mem_req,
   input  logic             mem_ready,
   output logic             freeze_front,
   output logic             bubble_exe,
   output logic             freeze_back,
   output logic             flush_front,
   output logic             mem_timeout
);

   localparam logic [WAIT_CNT_W-1:0] TIMEOUT_VAL = WAIT_CNT_W'(MEM_TIMEOUT);

   state_t                state, state_next;
   logic [WAIT_CNT_W-1:0] wait_cnt;
   logic [WAIT_CNT_W-1:0] wait_cnt_inc;
   logic                  timeout_q;
   logic                  hazard;
   logic                  mem_stall;

   hazard_detect_unit #(.REG_W(REG_W)) u_hdu (
      .id_src1      (id_src1),
      .id_src2      (id_src2),
      .id_two_src   (id_two_src),
      .exe_dest     (exe_dest),
      .exe_wb_en    (exe_wb_en),
      .exe_mem_read (exe_mem_read),
      .mem_dest     (mem_dest),
      .mem_wb_en    (mem_wb_en),
      .hazard       (hazard)
   );

   // The first cycle of an access (still IDLE) stalls exactly like MEM_WAIT; the ready cycle releases.
   assign mem_stall    = ((state == MEM_WAIT) | mem_req) & ~mem_ready;
   assign wait_cnt_inc = wait_cnt + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         wait_cnt  <= '0;
         timeout_q <= 1'b0;
      end else begin
         state <= state_next;
         if (state == IDLE) begin
            if (mem_req & ~mem_ready) wait_cnt <= '0;
         end else if (~mem_ready) begin
            if (wait_cnt != '1) wait_cnt <= wait_cnt_inc;
            if (wait_cnt_inc == TIMEOUT_VAL) timeout_q <= 1'b1;
         end
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:     if (mem_req & ~mem_ready) state_next = MEM_WAIT;
         MEM_WAIT: if (mem_ready) state_next = IDLE;
         default:  state_next = IDLE;
      endcase
   end

   always_comb begin
      freeze_front = 1'b0;
      bubble_exe   = 1'b0;
      freeze_back  = 1'b0;
      flush_front  = 1'b0;
      mem_timeout  = 1'b0;
      if (!rst) begin
         mem_timeout = timeout_q;
         if (mem_stall) begin
            freeze_front = 1'b1;
            freeze_back  = 1'b1;
         end else if (branch_taken) begin
            flush_front = 1'b1;
         end else if (hazard) begin
            freeze_front = 1'b1;
            bubble_exe   = 1'b1;
         end
      end
   end

endmodule
